// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: default sizing,
// special instruction encodings, address type and sequencer states.
package pc_sequencer_pkg;

  localparam int MEM_SIZE = 256;
  localparam int BIN_DIG  = 32;
  localparam int ADDR_W   = $clog2(MEM_SIZE);

  // All-ones word stops sequential fetch; all-zeros fills an empty latch.
  localparam logic [BIN_DIG-1:0] HALT_INST = {BIN_DIG{1'b1}};
  localparam logic [BIN_DIG-1:0] NOP_INST  = {BIN_DIG{1'b0}};

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC selection: redirect (with out-of-range clamp to 0),
// sequential advance with explicit wrap at MEM_SIZE-1, or hold.
module pc_next_calc #(
  parameter int MEM_SIZE = 256,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc_next
);

  // One extra bit so MEM_SIZE itself is representable for the range check.
  localparam logic [ADDR_W:0]   SIZE_X    = (ADDR_W + 1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO      = {ADDR_W{1'b0}};

  logic target_oob;

  assign target_oob = ({1'b0, redirect_addr} >= SIZE_X);

  // Redirect beats sequential advance; otherwise the PC holds.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = target_oob ? ZERO : redirect_addr;
    end else if (advance) begin
      pc_next = (pc == LAST_ADDR) ? ZERO : pc + ONE;
    end else begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch/decode latch. Drives the fetch address, captures
// the returned instruction with a valid/ready handshake toward decode, and
// handles stall, redirect-with-flush, wrap-around and halt.
module pc_sequencer #(
  parameter int                 MEM_SIZE   = pc_sequencer_pkg::MEM_SIZE,
  parameter int                 BIN_DIG    = pc_sequencer_pkg::BIN_DIG,
  parameter int                 ADDR_W     = $clog2(MEM_SIZE),
  parameter logic [ADDR_W-1:0]  START_ADDR = {ADDR_W{1'b0}},
  parameter logic [BIN_DIG-1:0] HALT_INST  = {BIN_DIG{1'b1}},
  parameter logic [BIN_DIG-1:0] NOP_INST   = {BIN_DIG{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic [BIN_DIG-1:0] fetch_inst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               dec_ready,
  output logic               dec_valid,
  output logic [BIN_DIG-1:0] dec_inst,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               halted
);

  import pc_sequencer_pkg::*;

  pc_state_t         state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic              capture_s;
  logic              is_halt_s;
  logic              advance_s;
  logic              redirect_s;

  // Fetch address is the PC register itself (fetchToDecode.addr).
  assign fetch_addr = pc_r;

  assign is_halt_s  = (fetch_inst == HALT_INST);
  assign capture_s  = (state_r == PC_RUN) && (!dec_valid || dec_ready) && !redirect_valid;
  assign advance_s  = capture_s && !is_halt_s;
  assign redirect_s = redirect_valid && (state_r != PC_BOOT);

  pc_next_calc #(
    .MEM_SIZE (MEM_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_next (
    .pc            (pc_r),
    .advance       (advance_s),
    .redirect      (redirect_s),
    .redirect_addr (redirect_addr),
    .pc_next       (pc_next_s)
  );

  // Sequencer state machine, PC register and fetch/decode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= PC_BOOT;
      pc_r      <= START_ADDR;
      dec_valid <= 1'b0;
      dec_inst  <= NOP_INST;
      dec_pc    <= {ADDR_W{1'b0}};
      halted    <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      case (state_r)
        PC_BOOT: begin
          state_r <= PC_RUN;
        end
        PC_RUN: begin
          if (redirect_valid) begin
            dec_valid <= 1'b0;
            dec_inst  <= NOP_INST;
          end else if (capture_s) begin
            dec_inst  <= fetch_inst;
            dec_pc    <= pc_r;
            dec_valid <= 1'b1;
            if (is_halt_s) begin
              state_r <= PC_HALT;
              halted  <= 1'b1;
            end else begin
              state_r <= PC_RUN;
            end
          end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
          end else begin
            dec_valid <= dec_valid;
          end
        end
        PC_HALT: begin
          if (redirect_valid) begin
            dec_valid <= 1'b0;
            dec_inst  <= NOP_INST;
            state_r   <= PC_RUN;
            halted    <= 1'b0;
          end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
          end else begin
            dec_valid <= dec_valid;
          end
        end
        default: begin
          state_r   <= PC_BOOT;
          dec_valid <= 1'b0;
          dec_inst  <= NOP_INST;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 256-word main instance and a 200-word
// instance for non-power-of-2 wrap and out-of-range redirect clamping.
module tb_pc_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [7:0]  fetch_addr;
  logic [31:0] fetch_inst;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [7:0]  dec_pc;
  logic        halted;

  logic [7:0]  fetch_addr2;
  logic [31:0] fetch_inst2;
  logic        redirect_valid2;
  logic [7:0]  redirect_addr2;
  logic        dec_valid2;
  logic [31:0] dec_inst2;
  logic [7:0]  dec_pc2;
  logic        halted2;

  logic [31:0] mem  [0:255];
  logic [31:0] mem2 [0:199];

  int n_vec = 0;
  int n_err = 0;

  assign fetch_inst  = mem[fetch_addr];
  assign fetch_inst2 = mem2[fetch_addr2];

  pc_sequencer #(.MEM_SIZE(256), .BIN_DIG(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_addr     (fetch_addr),
    .fetch_inst     (fetch_inst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .halted         (halted)
  );

  pc_sequencer #(.MEM_SIZE(200), .BIN_DIG(32)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .fetch_addr     (fetch_addr2),
    .fetch_inst     (fetch_inst2),
    .redirect_valid (redirect_valid2),
    .redirect_addr  (redirect_addr2),
    .dec_ready      (1'b1),
    .dec_valid      (dec_valid2),
    .dec_inst       (dec_inst2),
    .dec_pc         (dec_pc2),
    .halted         (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 200; i++) mem2[i] = 32'h100 + 32'(i);
    rst = 1'b1;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 8'h00;
    redirect_valid2 = 1'b0;
    redirect_addr2 = 8'h00;

    // 1. reset / boot
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_addr", fetch_addr, 8'h00);
    chk("rst_inst", dec_inst, 32'h0);
    chk("rst_halted", halted, 1'b0);
    rst = 1'b0;
    redirect_valid = 1'b1;  // ignored in BOOT
    redirect_addr = 8'h50;
    tick();
    redirect_valid = 1'b0;
    chk("boot_valid", dec_valid, 1'b0);
    chk("boot_addr", fetch_addr, 8'h00);
    tick();
    chk("e2_valid", dec_valid, 1'b1);
    chk("e2_pc", dec_pc, 8'h00);
    chk("e2_inst", dec_inst, 32'h100);
    tick();
    chk("e3_pc", dec_pc, 8'h01);
    chk("e3_inst", dec_inst, 32'h101);

    // 2. stall at dec_pc=3
    tick();
    tick();
    chk("pre_stall_pc", dec_pc, 8'h03);
    dec_ready = 1'b0;
    repeat (3) tick();
    chk("stall_pc", dec_pc, 8'h03);
    chk("stall_inst", dec_inst, 32'h103);
    chk("stall_addr", fetch_addr, 8'h04);
    chk("stall_valid", dec_valid, 1'b1);
    dec_ready = 1'b1;
    tick();
    chk("unstall_pc4", dec_pc, 8'h04);
    tick();
    chk("unstall_pc5", dec_pc, 8'h05);

    // 3. redirect during stall
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", dec_valid, 1'b0);
    chk("redir_addr", fetch_addr, 8'h40);
    chk("redir_nop", dec_inst, 32'h0);
    tick();
    chk("redir_pc", dec_pc, 8'h40);
    chk("redir_inst", dec_inst, 32'h140);
    chk("redir_valid2", dec_valid, 1'b1);

    // 4. halt at address 5
    mem[5] = HALT;
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 8'h03;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    chk("halt_pc", dec_pc, 8'h05);
    chk("halt_inst", dec_inst, HALT);
    chk("halt_flag", halted, 1'b1);
    chk("halt_addr", fetch_addr, 8'h05);
    tick();
    chk("halt_drain", dec_valid, 1'b0);
    repeat (3) tick();
    chk("halt_idle_valid", dec_valid, 1'b0);
    chk("halt_idle_addr", fetch_addr, 8'h05);
    redirect_valid = 1'b1;
    redirect_addr = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk("unhalt_flag", halted, 1'b0);
    chk("unhalt_addr", fetch_addr, 8'h10);
    tick();
    chk("unhalt_pc", dec_pc, 8'h10);
    chk("unhalt_inst", dec_inst, 32'h110);

    // 5. wrap at 255
    redirect_valid = 1'b1;
    redirect_addr = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc255", dec_pc, 8'hFF);
    chk("wrap_inst255", dec_inst, 32'h1FF);
    tick();
    chk("wrap_pc0", dec_pc, 8'h00);
    tick();
    chk("wrap_pc1", dec_pc, 8'h01);

    // 6. redirect colliding with a halt instruction
    mem[2] = HALT;
    chk("coll_pre_addr", fetch_addr, 8'h02);
    redirect_valid = 1'b1;
    redirect_addr = 8'h30;
    tick();
    redirect_valid = 1'b0;
    chk("coll_halted", halted, 1'b0);
    chk("coll_addr", fetch_addr, 8'h30);
    chk("coll_valid", dec_valid, 1'b0);
    tick();
    chk("coll_pc", dec_pc, 8'h30);
    chk("coll_inst", dec_inst, 32'h130);

    // async reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", dec_valid, 1'b0);
    chk("async_addr", fetch_addr, 8'h00);
    chk("async_inst", dec_inst, 32'h0);
    chk("async_pc", dec_pc, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("reboot_valid", dec_valid, 1'b0);
    tick();
    chk("reboot_pc", dec_pc, 8'h00);
    chk("reboot_inst", dec_inst, 32'h100);

    // non-power-of-2 instance: clamp and wrap
    redirect_valid2 = 1'b1;
    redirect_addr2 = 8'd250;
    tick();
    redirect_valid2 = 1'b0;
    chk("clamp_addr", fetch_addr2, 8'h00);
    chk("clamp_valid", dec_valid2, 1'b0);
    redirect_valid2 = 1'b1;
    redirect_addr2 = 8'd199;
    tick();
    redirect_valid2 = 1'b0;
    chk("w200_addr", fetch_addr2, 8'd199);
    tick();
    chk("w200_pc199", dec_pc2, 8'd199);
    chk("w200_wrap_addr", fetch_addr2, 8'd0);
    tick();
    chk("w200_pc0", dec_pc2, 8'd0);
    chk("w200_inst0", dec_inst2, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch-output stage that sits directly upstream of and around fetcher. It drives fetcher's address each cycle and captures the returned instruction into a registered fetch/decode latch with a valid/ready handshake toward decode. It handles stall, branch/jump redirect with flush, sequential wrap-around and halt detection.

Parameters:
ADDR_W, $clog2(MEM_SIZE), width of instruction address
START_ADDR, 0, PC value loaded on reset
HALT_INST, {BIN_DIG{1'b1}}, instruction encoding that stops sequential fetch
NOP_INST, '0, value of dec_inst while the latch is empty or in reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
fetch_addr  output  ADDR_W  address to fetcher (fetchToDecode.addr); equals PC register, combinational from it
fetch_inst  input  BIN_DIG  instruction returned by fetcher (fetchToDecode.curr_inst), valid in the same cycle
redirect_valid  input  1  branch/jump taken, from execute
redirect_addr  input  ADDR_W  redirect target
dec_ready  input  1  decode accepts dec_inst this cycle
dec_valid  output  1  dec_inst/dec_pc hold a valid instruction
dec_inst  output  BIN_DIG  latched instruction
dec_pc  output  ADDR_W  address of dec_inst
halted  output  1  sequencer is in HALT state

Behaviour:
- Reset (async, immediate, no clock edge needed): pc=START_ADDR, state=PC_BOOT, dec_valid=0, dec_inst=NOP_INST, dec_pc=0, halted=0.
- States: PC_BOOT -> PC_RUN unconditionally after one clock. No capture occurs in PC_BOOT. PC_RUN -> PC_HALT on a halt capture. PC_HALT -> PC_RUN on redirect_valid.
- capture = (state==PC_RUN) && (!dec_valid || dec_ready) && !redirect_valid.
- On capture: dec_inst<=fetch_inst, dec_pc<=pc, dec_valid<=1. If fetch_inst!=HALT_INST, then pc<=next(pc). Otherwise pc is held, state<=PC_HALT and halted<=1.
- No capture and dec_valid && dec_ready: dec_valid<=0. dec_inst and dec_pc keep their values.
- No capture and dec_valid && !dec_ready (stall): pc, dec_inst, dec_pc and dec_valid all hold.
- Throughput: one instruction per cycle when dec_ready is held at 1. Latency from fetch_addr=A to dec_valid with dec_pc=A is one edge.
- redirect_valid has highest priority in PC_RUN and PC_HALT, regardless of dec_ready:
  - pc<=redirect_addr, dec_valid<=0 (flush, in-flight instruction discarded), dec_inst<=NOP_INST.
  - In PC_HALT it additionally sets state<=PC_RUN and halted<=0.
  - redirect_valid is ignored in PC_BOOT.
- redirect_addr >= MEM_SIZE: treated as 0.
- next(pc): pc==MEM_SIZE-1 ? 0 : pc+1, using an explicit compare so it is correct for non-power-of-2 MEM_SIZE.
- A redirect and a HALT_INST on fetch_inst in the same cycle: redirect wins, the halt is not captured and the state does not change.
- PC_HALT: fetch_addr stays at the halt address. The halt instruction is still presented until decode accepts it, then dec_valid=0 until a redirect.
- Reset asserted mid-handshake: the latch is dropped and no partial state survives.

Decomposition:
- Add to package defs:
  - localparam ADDR_W
  - typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_t
  - HALT_INST and NOP_INST constants
  - typedef logic [ADDR_W-1:0] addr_t
- One natural sub-module, pc_next_calc: combinational next-PC mux covering wrap, redirect clamp and hold.
- Top-level wiring connects fetch_addr and fetch_inst to the fetchToDecode interface.

Test Plan (MEM_SIZE=256, BIN_DIG=32, memory[i]=i+0x100 unless stated):
1. Reset/boot: rst=1 for 3 cycles, dec_ready=1, then release -> edge 1: dec_valid=0 (BOOT), fetch_addr=0; edge 2: dec_valid=1, dec_pc=0, dec_inst=0x100; edge 3: dec_pc=1, dec_inst=0x101.
2. Stall: at dec_pc=3, hold dec_ready=0 for 3 cycles -> dec_pc=3, dec_inst=0x103, fetch_addr=4 stable. Set dec_ready=1 -> next edges give dec_pc=4, then 5.
3. Redirect during stall: dec_ready=0, redirect_valid=1 with redirect_addr=0x40 for one cycle -> next edge dec_valid=0, fetch_addr=0x40; following edge dec_pc=0x40, dec_inst=0x140.
4. Halt: memory[5]=HALT_INST -> dec_pc=5 with dec_inst=HALT_INST, halted=1, fetch_addr stays 5. After one dec_ready, dec_valid=0 indefinitely. Redirect to 0x10 -> halted=0, then dec_pc=0x10.
5. Wrap and clamp: redirect_addr=255 -> dec_pc sequence 255, 0, 1. redirect_addr=300 (wide bench) -> fetch_addr=0.
6. Collision and async reset: redirect_valid=1 while fetch_inst=HALT_INST -> halted stays 0 and fetch_addr=redirect target. Assert rst between edges -> dec_valid=0 and fetch_addr=0 immediately, before the next edge.
